// File: rtl/codec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codec_pkg
// Description : Shared constants, table value type and swap FSM states for
//               the quantisation-table controller.
// Revision    : 1.0 - initial release
// ============================================================================
package codec_pkg;

    localparam int BLK_COEF = 64;
    localparam int BEATS    = 32;
    localparam int QW       = 10;

    typedef logic [QW-1:0] qval_t;

    typedef enum logic [0:0] {
        SW_IDLE  = 1'b0,
        SW_ARMED = 1'b1
    } swap_st_t;

    // A zero divisor would break flow_divider, so it is stored as 1.
    function automatic qval_t clamp_q(input qval_t v);
        return (v == '0) ? qval_t'(1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quant_table_bank.sv
`default_nettype none
// ============================================================================
// Module      : quant_table_bank
// Description : Two 64-entry table banks with one write port and two
//               combinational read ports sharing a bank select.
// Revision    : 1.0 - initial release
// ============================================================================
module quant_table_bank
    import codec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic        wbank_i,
    input  logic [5:0]  waddr_i,
    input  qval_t       wdata_i,
    input  logic        rbank_i,
    input  logic [5:0]  raddr0_i,
    input  logic [5:0]  raddr1_i,
    output qval_t       rdata0_o,
    output qval_t       rdata1_o
);

    qval_t mem_q [2][BLK_COEF];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < BLK_COEF; a++) begin
                    mem_q[b][a] <= qval_t'(1);
                end
            end
        end else if (we_i) begin
            mem_q[wbank_i][waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[rbank_i][raddr0_i];
    assign rdata1_o = mem_q[rbank_i][raddr1_i];

endmodule
`default_nettype wire

// File: rtl/quant_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : quant_table_ctrl
// Description : One-stage pipeline that tags each coefficient beat with its
//               quantisation table pair; double-buffered table, frame swap.
// Revision    : 1.0 - initial release
// ============================================================================
module quant_table_ctrl
    import codec_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            in_valid_i,
    input  logic [N*DW-1:0] in_data_i,
    input  logic            in_sob_i,
    input  logic            in_eob_i,
    input  logic            in_sof_i,
    input  logic            cfg_we_i,
    input  logic [5:0]      cfg_addr_i,
    input  logic [QW-1:0]   cfg_data_i,
    input  logic            cfg_swap_i,
    output logic            cfg_pending_o,
    output logic            seq_err_o,
    output logic            out_valid_o,
    output logic [N*DW-1:0] out_data_o,
    output logic            out_sob_o,
    output logic            out_eob_o,
    output logic            out_sof_o,
    output logic [N*QW-1:0] out_q_o
);

    logic            beat;
    logic [4:0]      pos;
    logic [4:0]      bcnt_q, bcnt_d;
    logic            err_d;
    logic            apply;
    logic            rbank;
    qval_t           rdata0, rdata1;

    swap_st_t        swap_st_q;
    logic            active_q;
    logic            pending_q;
    logic            seq_err_q;

    logic            out_valid_q;
    logic [N*DW-1:0] out_data_q;
    logic            out_sob_q, out_eob_q, out_sof_q;
    logic [N*QW-1:0] out_q_q;

    assign beat   = en_i & in_valid_i;
    assign pos    = in_sob_i ? 5'd0 : bcnt_q;
    assign bcnt_d = in_sob_i ? 5'd1 : bcnt_q + 5'd1;
    assign err_d  = (in_sob_i & (bcnt_q != 5'd0))
                  | (in_eob_i & (pos != 5'(BEATS - 1)))
                  | (in_sof_i & ~in_sob_i);

    // The frame-start beat that applies the swap already reads the new bank.
    assign apply = beat & in_sof_i & in_sob_i & (swap_st_q == SW_ARMED);
    assign rbank = active_q ^ apply;

    quant_table_bank u_bank (
        .clk      (clk),
        .rst      (rst),
        .we_i     (cfg_we_i),
        .wbank_i  (~active_q),
        .waddr_i  (cfg_addr_i),
        .wdata_i  (clamp_q(cfg_data_i)),
        .rbank_i  (rbank),
        .raddr0_i ({pos, 1'b0}),
        .raddr1_i ({pos, 1'b1}),
        .rdata0_o (rdata0),
        .rdata1_o (rdata1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q    <= '0;
            seq_err_q <= 1'b0;
        end else if (beat) begin
            bcnt_q <= bcnt_d;
            if (err_d) begin
                seq_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            swap_st_q <= SW_IDLE;
            active_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            case (swap_st_q)
                SW_IDLE: begin
                    if (cfg_swap_i) begin
                        swap_st_q <= SW_ARMED;
                        pending_q <= 1'b1;
                    end
                end
                SW_ARMED: begin
                    if (apply) begin
                        swap_st_q <= SW_IDLE;
                        active_q  <= ~active_q;
                        pending_q <= 1'b0;
                    end
                end
                default: begin
                    swap_st_q <= SW_IDLE;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sob_q   <= 1'b0;
            out_eob_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            out_q_q     <= '0;
        end else if (en_i) begin
            out_valid_q <= in_valid_i;
            out_data_q  <= in_data_i;
            out_sob_q   <= in_sob_i;
            out_eob_q   <= in_eob_i;
            out_sof_q   <= in_sof_i;
            out_q_q     <= {rdata1, rdata0};
        end
    end

    assign cfg_pending_o = pending_q;
    assign seq_err_o     = seq_err_q;
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign out_sob_o     = out_sob_q;
    assign out_eob_o     = out_eob_q;
    assign out_sof_o     = out_sof_q;
    assign out_q_o       = out_q_q;

endmodule
`default_nettype wire
